tmds_channel_decoder: RTL

TMDS_CHANNEL_DECODER -- requirements
Module: tmds_channel_decoder

---
 rtl/tmds_pkg.sv | 36 +++
 rtl/tmds_symbol_decode.sv | 37 +++
 rtl/tmds_channel_decoder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS channel decoder: control tokens, TERC4 table,
// lock FSM states and the TMDS data-symbol decode rule.
package tmds_pkg;

   localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
   localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
   localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
   localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

   // Entry i is the 10-bit symbol q[9:0] carrying TERC4 nibble i.
   localparam logic [9:0] TERC4_TABLE [16] = '{
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
   };

   localparam logic [3:0] OFFSET_LAST = 4'd9;

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } lock_state_t;

   function automatic logic [7:0] tmds_data_decode(input logic [9:0] q);
      logic [7:0] d;
      logic [7:0] byte_out;
      d           = q[9] ? ~q[7:0] : q[7:0];
      byte_out[0] = d[0];
      for (int i = 1; i < 8; i++) begin
         byte_out[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      end
      return byte_out;
   endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational classifier for one aligned 10-bit TMDS symbol: control token,
// TERC4 nibble and video byte are all reported; the caller picks by priority.
module tmds_symbol_decode
   import tmds_pkg::*;
(
   input  logic [9:0] symbol,
   output logic       is_token,
   output logic [1:0] ctrl,
   output logic [7:0] data,
   output logic       is_terc4,
   output logic [3:0] terc4
);

   always_comb begin
      is_token = 1'b0;
      ctrl     = 2'b00;
      is_terc4 = 1'b0;
      terc4    = 4'h0;
      data     = tmds_data_decode(symbol);

      case (symbol)
         CTRL_TOKEN_00: begin is_token = 1'b1; ctrl = 2'b00; end
         CTRL_TOKEN_01: begin is_token = 1'b1; ctrl = 2'b01; end
         CTRL_TOKEN_10: begin is_token = 1'b1; ctrl = 2'b10; end
         CTRL_TOKEN_11: begin is_token = 1'b1; ctrl = 2'b11; end
         default: ;
      endcase

      for (int i = 0; i < 16; i++) begin
         if (symbol == TERC4_TABLE[i]) begin
            is_terc4 = 1'b1;
            terc4    = 4'(i);
         end
      end
   end

endmodule

// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: word alignment search on control tokens, lock tracking and
// 2-stage symbol decode. Define TMDS_DECODE_TERC4_EN to add TERC4 data-island outputs.
module tmds_channel_decoder
   import tmds_pkg::*;
#(
   parameter int LOCK_TOKENS   = 16,
   parameter int SEARCH_WINDOW = 1024,
   parameter int LOSS_WINDOW   = 2048
) (
   input  logic       clk_pixel,
   input  logic       reset,
   input  logic [9:0] raw_word,
   output logic [7:0] decoded,
   output logic [1:0] ctrl,
   output logic       de,
   output logic       locked,
   output logic [3:0] bit_offset
`ifdef TMDS_DECODE_TERC4_EN
   ,
   output logic       island,
   output logic [3:0] terc4
`endif
);

   localparam int TOK_W  = $clog2(LOCK_TOKENS + 1);
   localparam int WIN_W  = $clog2(SEARCH_WINDOW);
   localparam int LOSS_W = $clog2(LOSS_WINDOW);

   localparam logic [TOK_W-1:0]  TOKEN_LOCK = TOK_W'(LOCK_TOKENS);
   localparam logic [WIN_W-1:0]  WIN_LAST   = WIN_W'(SEARCH_WINDOW - 1);
   localparam logic [LOSS_W-1:0] LOSS_LAST  = LOSS_W'(LOSS_WINDOW - 1);

   logic [9:0]        prev_word;
   logic [18:0]       word_pair;
   logic [9:0]        aligned;
   logic [9:0]        sym_q;

   lock_state_t       state, state_next;
   logic [TOK_W-1:0]  token_cnt, token_cnt_next;
   logic [WIN_W-1:0]  win_cnt, win_cnt_next;
   logic [LOSS_W-1:0] loss_cnt, loss_cnt_next;
   logic [3:0]        bit_offset_next;

   logic              sym_is_token;
   logic [1:0]        sym_ctrl;
   logic [7:0]        sym_data;
   logic              sym_is_terc4;
   logic [3:0]        sym_terc4;

   logic [7:0]        decoded_next;
   logic [1:0]        ctrl_next;
   logic              de_next;
`ifdef TMDS_DECODE_TERC4_EN
   logic              island_next;
   logic [3:0]        terc4_next;
`else
   logic              unused_terc4;
   assign unused_terc4 = ^{sym_is_terc4, sym_terc4};
`endif

   // Offsets only reach 9, so the top bit of raw_word is never selected here.
   assign word_pair = {raw_word[8:0], prev_word};

   always_comb begin
      aligned = word_pair[9:0];
      for (int k = 1; k < 10; k++) begin
         if (bit_offset == 4'(k)) aligned = word_pair[k +: 10];
      end
   end

   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         prev_word <= '0;
         sym_q     <= '0;
      end else begin
         prev_word <= raw_word;
         sym_q     <= aligned;
      end
   end

   tmds_symbol_decode u_symbol_decode (
      .symbol   (sym_q),
      .is_token (sym_is_token),
      .ctrl     (sym_ctrl),
      .data     (sym_data),
      .is_terc4 (sym_is_terc4),
      .terc4    (sym_terc4)
   );

   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         state      <= SEARCH;
         token_cnt  <= '0;
         win_cnt    <= '0;
         loss_cnt   <= '0;
         bit_offset <= '0;
      end else begin
         state      <= state_next;
         token_cnt  <= token_cnt_next;
         win_cnt    <= win_cnt_next;
         loss_cnt   <= loss_cnt_next;
         bit_offset <= bit_offset_next;
      end
   end

   // A completed token run takes priority over the window expiring in the same cycle.
   always_comb begin
      state_next      = state;
      token_cnt_next  = token_cnt;
      win_cnt_next    = win_cnt;
      loss_cnt_next   = loss_cnt;
      bit_offset_next = bit_offset;
      case (state)
         SEARCH: begin
            if (token_cnt == TOKEN_LOCK) begin
               state_next     = LOCKED;
               token_cnt_next = '0;
               win_cnt_next   = '0;
               loss_cnt_next  = '0;
            end else if (win_cnt == WIN_LAST) begin
               bit_offset_next = (bit_offset == OFFSET_LAST) ? 4'd0 : bit_offset + 4'd1;
               token_cnt_next  = '0;
               win_cnt_next    = '0;
            end else begin
               win_cnt_next   = win_cnt + 1'b1;
               token_cnt_next = sym_is_token ? token_cnt + 1'b1 : '0;
            end
         end
         LOCKED: begin
            if (sym_is_token) begin
               loss_cnt_next = '0;
            end else if (loss_cnt == LOSS_LAST) begin
               state_next     = SEARCH;
               token_cnt_next = '0;
               win_cnt_next   = '0;
               loss_cnt_next  = '0;
            end else begin
               loss_cnt_next = loss_cnt + 1'b1;
            end
         end
         default: state_next = SEARCH;
      endcase
   end

   // Outputs follow the state being entered so they stay aligned with 'locked'.
   always_comb begin
      decoded_next = decoded;
      ctrl_next    = ctrl;
      de_next      = 1'b0;
`ifdef TMDS_DECODE_TERC4_EN
      island_next  = 1'b0;
      terc4_next   = terc4;
`endif
      if (state_next != LOCKED) begin
         decoded_next = '0;
         ctrl_next    = '0;
`ifdef TMDS_DECODE_TERC4_EN
         terc4_next   = '0;
`endif
      end else if (sym_is_token) begin
         ctrl_next = sym_ctrl;
`ifdef TMDS_DECODE_TERC4_EN
      end else if (sym_is_terc4) begin
         island_next = 1'b1;
         terc4_next  = sym_terc4;
`endif
      end else begin
         de_next      = 1'b1;
         decoded_next = sym_data;
      end
   end

   always_ff @(posedge clk_pixel or posedge reset) begin
      if (reset) begin
         decoded <= '0;
         ctrl    <= '0;
         de      <= 1'b0;
`ifdef TMDS_DECODE_TERC4_EN
         island  <= 1'b0;
         terc4   <= '0;
`endif
      end else begin
         decoded <= decoded_next;
         ctrl    <= ctrl_next;
         de      <= de_next;
`ifdef TMDS_DECODE_TERC4_EN
         island  <= island_next;
         terc4   <= terc4_next;
`endif
      end
   end

   assign locked = (state == LOCKED);

endmodule
